// File: rtl/gn_input_port.sv
// rtl/gn_input_port.sv - router input port: flit FIFO, XY route of head flit, grant-driven pop
module gn_input_port #(
   parameter logic [2:0] PORT_ID = 3'd0,
   parameter int         FLIT_W  = 16,
   parameter int         DEPTH   = 4,
   parameter logic [3:0] LOCAL_X = 4'd0,
   parameter logic [3:0] LOCAL_Y = 4'd0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [FLIT_W-1:0]          in_flit,
   output logic                       req_valid,
   output logic [2:0]                 req_dir,
   output logic [FLIT_W-1:0]          head_flit,
   output logic                       grant_hit,
   input  logic [2:0]                 ans_R,
   input  logic [2:0]                 ans_L,
   input  logic [2:0]                 ans_U,
   input  logic [2:0]                 ans_D,
   input  logic [2:0]                 ans_EJ,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [FLIT_W-1:0] head;
   logic [2:0]        route;
   logic [2:0]        ans_sel;
   logic              active;
   logic              full;
   logic              push;
   logic              pop;

   assign head     = mem[rd_ptr];
   assign full     = (count == CW'(DEPTH));
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = grant_hit;
   assign active   = (state == ST_REQ) || (state == ST_WAIT);

   // XY routing: resolve X first, then Y, eject when both coordinates match
   always_comb begin
      route = 3'b100;
      if (head[3:0] > LOCAL_X)
         route = 3'b000;
      else if (head[3:0] < LOCAL_X)
         route = 3'b001;
      else if (head[7:4] > LOCAL_Y)
         route = 3'b010;
      else if (head[7:4] < LOCAL_Y)
         route = 3'b011;
   end

   always_comb begin
      ans_sel = 3'b111;
      case (route)
         3'b000:  ans_sel = ans_R;
         3'b001:  ans_sel = ans_L;
         3'b010:  ans_sel = ans_U;
         3'b011:  ans_sel = ans_D;
         3'b100:  ans_sel = ans_EJ;
         default: ans_sel = 3'b111;
      endcase
   end

   assign req_valid = (state == ST_REQ);
   assign req_dir   = active ? route : 3'b111;
   assign head_flit = active ? head : '0;
   // Grants are registered one cycle behind the request, so only WAIT may consume them
   assign grant_hit = (state == ST_WAIT) && (ans_sel == PORT_ID);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (count != '0) state_nxt = ST_REQ;
         ST_REQ:  state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (!grant_hit)
               state_nxt = ST_REQ;
            else if ((count > CW'(1)) || push)
               state_nxt = ST_REQ;
            else
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (!push && pop)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_flit;
   end

endmodule

// File: tb/tb_gn_input_port.sv
// tb/tb_gn_input_port.sv - randomized scoreboard bench for gn_input_port with a queue-based reference model
module tb_gn_input_port;

   localparam int         DEPTH = 4;
   localparam logic [2:0] PID   = 3'd2;
   localparam logic [3:0] LX    = 4'd1;
   localparam logic [3:0] LY    = 4'd1;
   localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_flit;
   logic        req_valid;
   logic [2:0]  req_dir;
   logic [15:0] head_flit;
   logic        grant_hit;
   logic [2:0]  ans_R, ans_L, ans_U, ans_D, ans_EJ;
   logic [2:0]  count;

   gn_input_port #(.PORT_ID(PID), .FLIT_W(16), .DEPTH(DEPTH), .LOCAL_X(LX), .LOCAL_Y(LY)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .req_valid(req_valid), .req_dir(req_dir), .head_flit(head_flit), .grant_hit(grant_hit),
      .ans_R(ans_R), .ans_L(ans_L), .ans_U(ans_U), .ans_D(ans_D), .ans_EJ(ans_EJ), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] q[$];
   int          ph = PH_IDLE;
   bit          in_wait = 1'b0;
   bit          plan_grant = 1'b0;
   logic [2:0]  plan_ans [5] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
   int          policy = 0;   // 0 random, 1 always grant, 2 withhold, 3 stale grants only outside WAIT
   bit          m_hit, m_push;
   int          m_nph, m_mode, m_od;
   logic [2:0]  m_dir;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_route(input logic [15:0] f);
      int dx, dy;
      dx = f[3:0];
      dy = f[7:4];
      if (dx > int'(LX)) return 3'd0;
      if (dx < int'(LX)) return 3'd1;
      if (dy > int'(LY)) return 3'd2;
      if (dy < int'(LY)) return 3'd3;
      return 3'd4;
   endfunction

   // Monitor and scoreboard: checks this cycle, then advances the model across the next edge
   always @(negedge clk) begin
      if (!reset) begin
         check("rst_count", count, 0);
         check("rst_in_ready", in_ready, 1);
         check("rst_req_valid", req_valid, 0);
         check("rst_req_dir", req_dir, 3'b111);
         check("rst_head_flit", head_flit, 0);
         check("rst_grant_hit", grant_hit, 0);
         q.delete();
         ph = PH_IDLE;
         in_wait = 1'b0;
         plan_grant = 1'b0;
         foreach (plan_ans[i]) plan_ans[i] = 3'b111;
      end else begin
         in_wait = (ph == PH_WAIT);
         check("req_valid", req_valid, ph == PH_REQ);
         if (ph != PH_IDLE) begin
            check("req_dir", req_dir, ref_route(q[0]));
            check("head_flit", head_flit, q[0]);
         end else begin
            check("idle_req_dir", req_dir, 3'b111);
         end
         m_hit = (ph == PH_WAIT) && plan_grant;
         check("grant_hit", grant_hit, m_hit);
         check("count", count, q.size());
         check("in_ready", in_ready, q.size() < DEPTH);
         m_push = in_valid && (q.size() < DEPTH);
         case (ph)
            PH_IDLE: m_nph = (q.size() != 0) ? PH_REQ : PH_IDLE;
            PH_REQ:  m_nph = PH_WAIT;
            default: m_nph = m_hit ? (((q.size() > 1) || m_push) ? PH_REQ : PH_IDLE) : PH_REQ;
         endcase
         if (m_hit) void'(q.pop_front());
         if (m_push) q.push_back(in_flit);
         ph = m_nph;
         plan_grant = 1'b0;
         foreach (plan_ans[i]) plan_ans[i] = 3'b111;
         if (ph == PH_WAIT) begin
            m_dir = ref_route(q[0]);
            case (policy)
               1:       m_mode = 0;
               2:       m_mode = $urandom_range(1, 3);
               3:       m_mode = 1;
               default: m_mode = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            endcase
            m_od = (int'(m_dir) + 1 + $urandom_range(0, 3)) % 5;
            case (m_mode)
               0: begin plan_ans[m_dir] = PID; plan_grant = 1'b1; end
               2: plan_ans[m_dir] = 3'((int'(PID) + 1 + $urandom_range(0, 3)) % 5);
               3: plan_ans[m_od] = PID;
               default: ;
            endcase
         end else if (policy == 3 || (policy == 0 && $urandom_range(0, 1) == 1)) begin
            foreach (plan_ans[i]) plan_ans[i] = PID;
         end
      end
   end

   // Responder standing in for gn_select: registered answers appear just after the edge
   always @(posedge clk) begin
      #1;
      ans_R  = plan_ans[0];
      ans_L  = plan_ans[1];
      ans_U  = plan_ans[2];
      ans_D  = plan_ans[3];
      ans_EJ = plan_ans[4];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [15:0] f);
      cyc();
      in_valid = 1'b1;
      in_flit  = f;
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin
      bit found;
      reset = 1'b0;
      in_valid = 1'b1;
      in_flit = 16'h1234;
      {ans_R, ans_L, ans_U, ans_D, ans_EJ} = {5{3'b111}};
      repeat (3) cyc();
      in_valid = 1'b0;
      reset = 1'b1;

      policy = 1;
      push_one({8'hA5, 4'h0, 4'h3});
      repeat (6) cyc();

      in_valid = 1'b1;
      in_flit = {8'h11, 4'h3, 4'h1};
      cyc();
      in_flit = {8'h22, 4'h0, 4'h1};
      cyc();
      in_flit = {8'h33, 4'h1, 4'h1};
      cyc();
      in_valid = 1'b0;
      repeat (10) cyc();

      policy = 2;
      push_one({8'h44, 4'h2, 4'h0});
      repeat (7) cyc();
      policy = 1;
      repeat (5) cyc();

      policy = 2;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_flit = 16'($urandom);
         cyc();
      end
      policy = 1;
      repeat (4) cyc();
      in_valid = 1'b0;
      repeat (20) cyc();

      policy = 3;
      push_one({8'h55, 4'h1, 4'h2});
      push_one({8'h66, 4'h3, 4'h3});
      repeat (6) cyc();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         #2;
         found = in_wait;
      end
      check("wait_reached", found, 1);
      reset = 1'b0;
      #1;
      check("async_count", count, 0);
      check("async_req_valid", req_valid, 0);
      check("async_req_dir", req_dir, 3'b111);
      check("async_grant_hit", grant_hit, 0);
      repeat (2) cyc();
      reset = 1'b1;

      policy = 0;
      for (int i = 0; i < 2000; i++) begin
         cyc();
         in_valid = ($urandom_range(0, 99) < 45);
         in_flit  = 16'($urandom);
      end
      cyc();
      in_valid = 1'b0;
      policy = 1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         cyc();
         found = (q.size() == 0) && (ph == PH_IDLE);
      end
      check("drain_done", found, 1);
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
